// File: rtl/cc_pkg.sv
// Shared constants and types for the cache-controller miss path.
// AXI burst encodings, line geometry and the miss-request FSM states.
package cc_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;

    localparam int         CC_LINE_BEATS = 8;
    localparam logic [2:0] CC_BEAT_SIZE  = 3'b011;

    typedef enum logic {
        IDLE,
        REQ
    } cc_miss_req_state_t;

endpackage

// File: rtl/cc_txn_counter.sv
// Saturating up/down counter of transactions in flight.
// Reused for any issue/complete pair (miss reads, write-backs).
module cc_txn_counter #(
    parameter  int MAX = 4,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full
);

    localparam logic [W-1:0] MAX_W = W'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (count != MAX_W) count <= count + 1'b1;
        end else if (dec && !inc) begin
            if (count != '0) count <= count - 1'b1;
        end
    end

    assign full = (count >= MAX_W);

    // A completion with nothing in flight means the upstream bookkeeping is broken.
    a_no_underflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(dec && !inc && count == '0)
    );

endmodule

// File: rtl/cc_miss_req_unit.sv
// Miss request unit: one miss at a time -> AXI AR line burst + miss-address FIFO push.
// CC_CRITICAL_WORD_FIRST_EN selects doubleword-aligned WRAP bursts instead of line-aligned INCR.
module cc_miss_req_unit
    import cc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_req_valid_i,
    input  logic [31:0] miss_req_addr_i,
    output logic        miss_req_ready_o,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    input  logic        mem_rvalid_i,
    input  logic        mem_rready_i,
    input  logic        mem_rlast_i,
    input  logic        miss_addr_fifo_full_i,
    output logic        miss_addr_fifo_wren_o,
    output logic [31:0] miss_addr_fifo_wdata_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

`ifdef CC_CRITICAL_WORD_FIRST_EN
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFF8;
    localparam logic [1:0]  BURST     = AXI_BURST_WRAP;
`else
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFC0;
    localparam logic [1:0]  BURST     = AXI_BURST_INCR;
`endif

    cc_miss_req_state_t state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   outstanding;
    logic               cnt_full;
    logic               ar_hs;
    logic               r_last_hs;

    assign ar_hs     = mem_arvalid_o & mem_arready_i;
    assign r_last_hs = mem_rvalid_i & mem_rready_i & mem_rlast_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        addr_d                = addr_q;
        miss_req_ready_o      = 1'b0;
        mem_arvalid_o         = 1'b0;
        miss_addr_fifo_wren_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Reset is folded in so ready is low during reset, not just after it.
                miss_req_ready_o = rst_n & !miss_addr_fifo_full_i & !cnt_full;
                if (miss_req_valid_i && miss_req_ready_o) begin
                    addr_d  = miss_req_addr_i & ADDR_MASK;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_arvalid_o = 1'b1;
                if (mem_arready_i) begin
                    miss_addr_fifo_wren_o = 1'b1;
                    state_d               = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_araddr_o           = addr_q;
    assign miss_addr_fifo_wdata_o = addr_q;
    assign mem_arlen_o            = 4'(CC_LINE_BEATS - 1);
    assign mem_arsize_o           = CC_BEAT_SIZE;
    assign mem_arburst_o          = BURST;

    cc_txn_counter #(
        .MAX (MAX_OUTSTANDING)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ar_hs),
        .dec   (r_last_hs),
        .count (outstanding),
        .full  (cnt_full)
    );

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(miss_addr_fifo_wren_o && miss_addr_fifo_full_i)
    );

endmodule
